// File: rtl/qam16_pkg.sv
// ---------------------------------------------------------------------------
// qam16_pkg
// Constants shared by the QAM16 transmit packetizer, the mapper/slicer and the
// receive-side unpacker. No ports; import with `import qam16_pkg::*;`.
//   QAM16_SYMBOL_W    : bits carried by one QAM16 symbol (one nibble)
//   QAM16_NIBBLES_DEF : default number of symbols packed into one word
//   QAM16_WORD_W      : default packed word width
// ---------------------------------------------------------------------------
package qam16_pkg;

    localparam int QAM16_SYMBOL_W    = 4;
    localparam int QAM16_NIBBLES_DEF = 8;
    localparam int QAM16_WORD_W      = QAM16_SYMBOL_W * QAM16_NIBBLES_DEF;

endpackage : qam16_pkg

// File: rtl/qam16_data_unpacket.sv
// ---------------------------------------------------------------------------
// qam16_data_unpacket
// Reassembles 4-bit demodulated QAM16 symbols into 4*NIBBLES-bit words. The
// first symbol of a word lands in bits [3:0]. A symbol carrying tlast closes
// the word early; unused upper nibble slots are zero and m_axis_tuser reports
// how many nibbles are valid.
//
// Ports:
//   aclk, reset            clock and synchronous active-high reset
//   s_axis_tdata/tvalid/tlast/tready   symbol input (AXI-Stream slave)
//   m_axis_tdata/tvalid/tlast/tuser/tready  word output (AXI-Stream master)
// ---------------------------------------------------------------------------
module qam16_data_unpacket
    import qam16_pkg::*;
#(
    parameter int NIBBLES = QAM16_NIBBLES_DEF,
    parameter int CNT_W   = 4
) (
    input  logic                              aclk,
    input  logic                              reset,
    input  logic [QAM16_SYMBOL_W-1:0]         s_axis_tdata,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,
    output logic [QAM16_SYMBOL_W*NIBBLES-1:0] m_axis_tdata,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    output logic [CNT_W-1:0]                  m_axis_tuser,
    input  logic                              m_axis_tready
);

    localparam int              W        = QAM16_SYMBOL_W * NIBBLES;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NIBBLES - 1);

    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [W-1:0]     asm_q,    asm_d;
    logic [W-1:0]     tdata_q,  tdata_d;
    logic             tvalid_q, tvalid_d;
    logic             tlast_q,  tlast_d;
    logic [CNT_W-1:0] tuser_q,  tuser_d;

    logic [W-1:0]     merged;
    logic             accept;
    logic             complete;

    // Combinational path from m_axis_tready: the single output register can
    // take a new word in the same cycle the current one is consumed, which is
    // what gives one symbol per clock without a skid buffer.
    assign s_axis_tready = !reset && (!tvalid_q || m_axis_tready);
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign complete      = accept && (s_axis_tlast || (cnt_q == LAST_IDX));

    // Assembly word with the incoming nibble placed in slot cnt. Slots above
    // cnt are forced to zero so a short (tlast) word never carries stale data.
    always_comb begin
        merged = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (i < int'(cnt_q)) begin
                merged[i*QAM16_SYMBOL_W +: QAM16_SYMBOL_W] = asm_q[i*QAM16_SYMBOL_W +: QAM16_SYMBOL_W];
            end else if (i == int'(cnt_q)) begin
                merged[i*QAM16_SYMBOL_W +: QAM16_SYMBOL_W] = s_axis_tdata;
            end
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        asm_d    = asm_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        tuser_d  = tuser_q;

        if (tvalid_q && m_axis_tready) begin
            tvalid_d = 1'b0;
        end

        // A completing beat overrides the consume above so tvalid stays high
        // when a word is handed off and the next one lands in the same cycle.
        if (accept) begin
            if (complete) begin
                cnt_d    = '0;
                asm_d    = '0;
                tdata_d  = merged;
                tuser_d  = cnt_q + 1'b1;
                tlast_d  = s_axis_tlast;
                tvalid_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
                asm_d = merged;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            cnt_q    <= '0;
            asm_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tuser_q  <= '0;
        end else begin
            cnt_q    <= cnt_d;
            asm_q    <= asm_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            tuser_q  <= tuser_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tuser  = tuser_q;

endmodule : qam16_data_unpacket

// File: tb/tb_qam16_data_unpacket.sv
// ---------------------------------------------------------------------------
// tb_qam16_data_unpacket
// Directed scenarios with literal expectations followed by a randomized run
// (input gaps, random downstream ready, periodic tlast). A behavioural model
// groups accepted nibbles into words; the monitor compares every visible
// output beat against it.
// ---------------------------------------------------------------------------
module tb_qam16_data_unpacket;

    localparam int NIB = 8;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tlast;
    logic          s_axis_tready;
    logic [31:0]   m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic [CW-1:0] m_axis_tuser;
    logic          m_axis_tready;

    always #5 clk = ~clk;

    qam16_data_unpacket #(.NIBBLES(NIB), .CNT_W(CW)) dut (
        .aclk          (clk),
        .reset         (reset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tready (m_axis_tready)
    );

    typedef struct {
        logic [31:0] d;
        int          u;
        logic        l;
        int          cyc;
    } word_t;

    word_t      expq[$];
    word_t      logq[$];
    logic [3:0] part[$];

    int n_chk = 0;
    int n_err = 0;
    int n_cyc = 0;
    logic rnd_rdy = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, n_cyc);
        end
    endtask

    // Monitor / scoreboard, sampled on the falling edge.
    logic        rst_prev  = 1'b0;
    logic        hold_prev = 1'b0;
    logic        pend      = 1'b0;
    logic [31:0] pd;
    logic        pl;
    logic [3:0]  pu;

    always @(negedge clk) begin
        word_t w;
        n_cyc++;
        chk("s_tready", {63'd0, s_axis_tready},
            {63'd0, (!reset && (!m_axis_tvalid || m_axis_tready))});
        if (rst_prev) begin
            chk("rst_out", {m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser}, 64'd0);
        end else begin
            if (pend) chk("latency", {63'd0, m_axis_tvalid}, 64'd1);
            if (hold_prev)
                chk("hold", {m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser},
                    {1'b1, pd, pl, pu});
            if (m_axis_tvalid) begin
                if (expq.size() == 0) begin
                    chk("spurious", 64'd1, 64'd0);
                end else begin
                    chk("tdata", m_axis_tdata, expq[0].d);
                    chk("tuser", m_axis_tuser, expq[0].u);
                    chk("tlast", m_axis_tlast, expq[0].l);
                    if (m_axis_tready && !reset) begin
                        w.d = m_axis_tdata; w.u = int'(m_axis_tuser);
                        w.l = m_axis_tlast; w.cyc = n_cyc;
                        logq.push_back(w);
                        void'(expq.pop_front());
                    end
                end
            end
        end
        pend      = 1'b0;
        hold_prev = m_axis_tvalid && !m_axis_tready && !reset;
        pd = m_axis_tdata; pl = m_axis_tlast; pu = m_axis_tuser;
        if (reset) begin
            part.delete();
            expq.delete();
        end else if (s_axis_tvalid && s_axis_tready) begin
            part.push_back(s_axis_tdata);
            if (part.size() == NIB || s_axis_tlast) begin
                w.d = 32'd0;
                for (int k = 0; k < part.size(); k++) w.d = w.d | (32'(part[k]) << (4 * k));
                w.u = part.size(); w.l = s_axis_tlast; w.cyc = 0;
                expq.push_back(w);
                part.delete();
                pend = 1'b1;
            end
        end
        rst_prev = reset;
    end

    always @(posedge clk) begin
        #1;
        if (rnd_rdy) m_axis_tready = 1'($urandom % 2);
    end

    task automatic send(input logic [3:0] n, input logic l);
        int w;
        s_axis_tdata  = n;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        w = 0;
        @(negedge clk);
        while (!s_axis_tready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) chk("send_timeout", 64'(w), 64'd0);
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic idle(input int n);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        reset = 1'b1; s_axis_tvalid = 1'b0; s_axis_tdata = 4'h0;
        s_axis_tlast = 1'b0; m_axis_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
        chk("rst_s_tready", {63'd0, s_axis_tready}, 64'd0);
        reset = 1'b0;

        // 1..8 with tlast on the eighth
        b = logq.size();
        for (int i = 1; i <= 8; i++) send(4'(i), i == 8);
        idle(3);
        chk("t1_count", 64'(logq.size() - b), 64'd1);
        if (logq.size() > b) begin
            chk("t1_data", logq[b].d, 64'h87654321);
            chk("t1_user", 64'(logq[b].u), 64'd8);
            chk("t1_last", {63'd0, logq[b].l}, 64'd1);
        end

        // 0..F continuous, two words, eight cycles apart
        b = logq.size();
        for (int i = 0; i < 16; i++) send(4'(i), 1'b0);
        idle(3);
        chk("t2_count", 64'(logq.size() - b), 64'd2);
        if (logq.size() > b + 1) begin
            chk("t2_w0", logq[b].d, 64'h76543210);
            chk("t2_w0_last", {63'd0, logq[b].l}, 64'd0);
            chk("t2_w1", logq[b+1].d, 64'hFEDCBA98);
            chk("t2_gap", 64'(logq[b+1].cyc - logq[b].cyc), 64'd8);
        end

        // Backpressure with a pending word
        m_axis_tready = 1'b0;
        b = logq.size();
        for (int i = 1; i <= 8; i++) send(4'(i), 1'b0);
        repeat (5) begin
            @(negedge clk);
            chk("t3_stall_s_tready", {63'd0, s_axis_tready}, 64'd0);
            chk("t3_stall_tdata", 64'(m_axis_tdata), 64'h87654321);
        end
        @(posedge clk);
        #1;
        m_axis_tready = 1'b1;
        send(4'h9, 1'b0); send(4'hA, 1'b0); send(4'hB, 1'b0); send(4'hC, 1'b0);
        send(4'hD, 1'b0); send(4'hE, 1'b0); send(4'hF, 1'b0); send(4'h1, 1'b0);
        idle(3);
        chk("t3_count", 64'(logq.size() - b), 64'd2);
        if (logq.size() > b + 1) begin
            chk("t3_w0", logq[b].d, 64'h87654321);
            chk("t3_w1", logq[b+1].d, 64'h1FEDCBA9);
        end

        // Short words
        b = logq.size();
        send(4'hA, 1'b0); send(4'hB, 1'b0); send(4'hC, 1'b1);
        send(4'h5, 1'b1);
        idle(3);
        chk("t4_count", 64'(logq.size() - b), 64'd2);
        if (logq.size() > b + 1) begin
            chk("t4_w0", logq[b].d, 64'h00000CBA);
            chk("t4_u0", 64'(logq[b].u), 64'd3);
            chk("t4_l0", {63'd0, logq[b].l}, 64'd1);
            chk("t4_w1", logq[b+1].d, 64'h00000005);
            chk("t4_u1", 64'(logq[b+1].u), 64'd1);
        end

        // Reset mid-word discards the partial word
        for (int i = 0; i < 5; i++) send(4'(i + 3), 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_rst_out", {m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser}, 64'd0);
        chk("t5_rst_s_tready", {63'd0, s_axis_tready}, 64'd0);
        reset = 1'b0;
        b = logq.size();
        for (int i = 1; i <= 8; i++) send(4'(i), i == 8);
        idle(3);
        chk("t5_count", 64'(logq.size() - b), 64'd1);
        if (logq.size() > b) begin
            chk("t5_data", logq[b].d, 64'h87654321);
            chk("t5_user", 64'(logq[b].u), 64'd8);
        end

        // Randomized traffic
        rnd_rdy = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom % 2 == 0) idle(1);
            send(4'($urandom), (i % 13 == 12) || ($urandom % 16 == 0) || (i == 999));
        end
        rnd_rdy = 1'b0;
        m_axis_tready = 1'b1;
        idle(20);
        chk("rand_drain", 64'(expq.size()), 64'd0);
        chk("rand_partial", 64'(part.size()), 64'd0);
        chk("rand_tvalid_idle", {63'd0, m_axis_tvalid}, 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_qam16_data_unpacket
